// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: arbitrates flap/score/hit requests and walks
// each effect's note list from a sync ROM, driving one tone generator.
// Ports: clk, resetn (async low), req[2:0] pulses, mute level,
//   rom_addr/rom_data (1-cycle ROM), note_idx/tone_en to tone gen,
//   busy, active_id, done pulse with done_id.
module sfx_sequencer #(
  parameter int NOTE_TICKS = 12500000,
  parameter int SEQ_LEN    = 8,
  parameter int NOTE_W     = 5,
  parameter int ADDR_W     = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [2:0]        req,
  input  logic              mute,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_data,
  output logic [NOTE_W-1:0] note_idx,
  output logic              tone_en,
  output logic              busy,
  output logic [1:0]        active_id,
  output logic              done,
  output logic [1:0]        done_id
);

  localparam int SLOT_W =
    (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int SHIFT  =
    (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 0;
  localparam int TICK_W = $clog2(NOTE_TICKS);

  localparam logic [SLOT_W-1:0] SLOT_LAST =
    SLOT_W'(SEQ_LEN - 1);
  localparam logic [TICK_W-1:0] TICK_LAST =
    TICK_W'(NOTE_TICKS - 1);
  localparam logic [NOTE_W-1:0] CODE_END =
    NOTE_W'(31);
  localparam logic [NOTE_W-1:0] CODE_MAX =
    NOTE_W'(16);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY,
    FINISH
  } state_t;

  state_t            state;
  logic [2:0]        pending;
  logic [SLOT_W-1:0] slot;
  logic [TICK_W-1:0] tick;

  logic [1:0]        hp;
  logic [2:0]        gmask;
  logic              can_grant;
  logic              playing;
  logic              preempt;
  logic              grant;
  logic [ADDR_W-1:0] base;
  logic              is_end;
  logic              is_tone;

  // Ids are numbered in priority order, so the
  // highest set bit is the winner.
  always_comb begin
    hp = 2'd0;
    priority case (1'b1)
      pending[2]: hp = 2'd2;
      pending[1]: hp = 2'd1;
      default:    hp = 2'd0;
    endcase
  end

  assign gmask     = 3'b001 << hp;
  assign can_grant = (|pending) && !mute;
  assign playing   = (state == FETCH) ||
                     (state == LOAD)  ||
                     (state == PLAY);
  assign preempt   = playing && can_grant &&
                     (hp > active_id);
  assign grant     = preempt ||
                     ((state == IDLE) && can_grant);
  assign base      = ADDR_W'(hp) << SHIFT;
  assign is_end    = (rom_data == CODE_END);
  assign is_tone   = (rom_data <= CODE_MAX);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      pending   <= '0;
      slot      <= '0;
      tick      <= '0;
      rom_addr  <= '0;
      note_idx  <= '0;
      tone_en   <= 1'b0;
      active_id <= 2'd0;
      done      <= 1'b0;
      done_id   <= 2'd0;
    end else begin
      done <= 1'b0;

      // A new request beats the clear of a grant.
      if (mute) begin
        pending <= '0;
      end else begin
        pending <= (pending &
                    ~(grant ? gmask : 3'b000)) |
                   req;
      end

      if (mute && (state != IDLE)) begin
        state     <= IDLE;
        tone_en   <= 1'b0;
        active_id <= 2'd0;
      end else if (grant) begin
        active_id <= hp;
        slot      <= '0;
        rom_addr  <= base;
        state     <= FETCH;
      end else begin
        unique case (state)
          IDLE: begin
          end
          FETCH: begin
            state <= LOAD;
          end
          LOAD: begin
            if (is_end) begin
              state   <= FINISH;
              tone_en <= 1'b0;
              done    <= 1'b1;
              done_id <= active_id;
            end else begin
              if (is_tone) begin
                note_idx <= rom_data;
                tone_en  <= 1'b1;
              end else begin
                tone_en  <= 1'b0;
              end
              tick  <= '0;
              state <= PLAY;
            end
          end
          PLAY: begin
            if (tick == TICK_LAST) begin
              if (slot == SLOT_LAST) begin
                state   <= FINISH;
                tone_en <= 1'b0;
                done    <= 1'b1;
                done_id <= active_id;
              end else begin
                slot     <= slot + SLOT_W'(1);
                rom_addr <= rom_addr + ADDR_W'(1);
                state    <= FETCH;
              end
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end
          FINISH: begin
            active_id <= 2'd0;
            state     <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Scoreboard bench for sfx_sequencer: note/rest/done events are queued
// with their expected cycle and popped by an output monitor.
module tb_sfx_sequencer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] req = 3'b000;
  logic       mute = 1'b0;
  logic [4:0] rom_addr;
  logic [4:0] rom_data;
  logic [4:0] note_idx;
  logic       tone_en;
  logic       busy;
  logic [1:0] active_id;
  logic       done;
  logic [1:0] done_id;

  logic [4:0] mem [32];

  localparam logic [1:0] E_NOTE = 2'd0;
  localparam logic [1:0] E_OFF  = 2'd1;
  localparam logic [1:0] E_DONE = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  val;
    logic [31:0] t;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  total = 0;
  int  passed = 0;
  int  maxa = 0;

  sfx_sequencer #(
    .NOTE_TICKS(4),
    .SEQ_LEN(8),
    .NOTE_W(5),
    .ADDR_W(5)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .req(req),
    .mute(mute),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .note_idx(note_idx),
    .tone_en(tone_en),
    .busy(busy),
    .active_id(active_id),
    .done(done),
    .done_id(done_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data <= mem[rom_addr];
    cyc      <= cyc + 1;
  end

  logic       pe;
  logic [4:0] pn;
  ev_t        me;
  ev_t        mx;
  bit         has;

  initial begin
    pe = 1'b0;
    pn = 5'd0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        pe = 1'b0;
        pn = 5'd0;
      end else begin
        has  = 1'b1;
        me.t = 32'(cyc);
        if (done) begin
          me.kind = E_DONE;
          me.val  = {3'b000, done_id};
        end else if (tone_en &&
                     (!pe || note_idx != pn)) begin
          me.kind = E_NOTE;
          me.val  = note_idx;
        end else if (!tone_en && pe) begin
          me.kind = E_OFF;
          me.val  = note_idx;
        end else begin
          has = 1'b0;
        end
        if (busy && active_id == 2'd1 &&
            int'(rom_addr) > maxa)
          maxa = int'(rom_addr);
        if (has) begin
          total++;
          if (q.size() == 0) begin
            $display("FAIL event: unexpected kind=%0d val=%0d cyc=%0d",
                     me.kind, me.val, me.t);
          end else begin
            mx = q.pop_front();
            if (mx == me)
              passed++;
            else
              $display({"FAIL event: got kind=%0d val=%0d cyc=%0d",
                        " expected kind=%0d val=%0d cyc=%0d"},
                       me.kind, me.val, me.t,
                       mx.kind, mx.val, mx.t);
          end
        end
        pe = tone_en;
        pn = note_idx;
      end
    end
  end

  task automatic chk(input string name,
                     input int act, input int exp);
    total++;
    if (act == exp)
      passed++;
    else
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
  endtask

  task automatic at(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push(input logic [1:0] k,
                      input int v, input int t);
    ev_t e;
    e.kind = k;
    e.val  = 5'(v);
    e.t    = 32'(t);
    q.push_back(e);
  endtask

  task automatic pulse(input logic [2:0] r);
    req = r;
    @(negedge clk);
    req = 3'b000;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d events outstanding, expected 0",
               q.size());
      q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic run_flap();
    int c;
    c = cyc;
    push(E_NOTE, 3, c + 4);
    push(E_NOTE, 5, c + 10);
    push(E_DONE, 0, c + 16);
    pulse(3'b001);
    at(c + 2);
    chk("flap_addr", int'(rom_addr), 0);
    chk("flap_busy", int'(busy), 1);
    at(c + 4);
    chk("flap_en", int'(tone_en), 1);
    chk("flap_note", int'(note_idx), 3);
    at(c + 16);
    chk("flap_done", int'(done), 1);
    chk("flap_done_busy", int'(busy), 1);
    at(c + 17);
    chk("flap_done_low", int'(done), 0);
    chk("flap_busy_low", int'(busy), 0);
    drain(60);
  endtask

  int c;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 5'h1F;
    mem[0]  = 5'd3;
    mem[1]  = 5'd5;
    for (int i = 0; i < 8; i++) mem[8 + i] = 5'(i + 1);
    mem[16] = 5'd2;
    mem[17] = 5'h1E;
    mem[18] = 5'd4;

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_addr", int'(rom_addr), 0);
    chk("rst_note", int'(note_idx), 0);
    chk("rst_en", int'(tone_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_id", int'(active_id), 0);
    chk("rst_done", int'({done, done_id}), 0);

    run_flap();

    c = cyc;
    push(E_NOTE, 2, c + 4);
    push(E_OFF, 2, c + 10);
    push(E_NOTE, 4, c + 16);
    push(E_DONE, 2, c + 22);
    pulse(3'b100);
    at(c + 10);
    chk("rest_en", int'(tone_en), 0);
    chk("rest_hold", int'(note_idx), 2);
    drain(60);

    c = cyc;
    push(E_NOTE, 3, c + 4);
    push(E_NOTE, 2, c + 9);
    push(E_OFF, 2, c + 15);
    push(E_NOTE, 4, c + 21);
    push(E_DONE, 2, c + 27);
    pulse(3'b001);
    at(c + 5);
    pulse(3'b100);
    chk("pre_wait_id", int'(active_id), 0);
    at(c + 7);
    chk("pre_id", int'(active_id), 2);
    chk("pre_addr", int'(rom_addr), 16);
    drain(80);

    c = cyc;
    for (int k = 0; k < 8; k++)
      push(E_NOTE, k + 1, c + 4 + 6 * k);
    push(E_DONE, 1, c + 50);
    push(E_NOTE, 3, c + 54);
    push(E_NOTE, 5, c + 60);
    push(E_DONE, 0, c + 66);
    pulse(3'b011);
    at(c + 2);
    chk("dual_first_id", int'(active_id), 1);
    drain(200);
    chk("score_max_addr", maxa, 15);

    c = cyc;
    push(E_NOTE, 3, c + 4);
    push(E_OFF, 3, c + 6);
    pulse(3'b001);
    at(c + 5);
    mute = 1'b1;
    at(c + 6);
    chk("mute_en", int'(tone_en), 0);
    chk("mute_busy", int'(busy), 0);
    chk("mute_id", int'(active_id), 0);
    pulse(3'b111);
    at(c + 9);
    mute = 1'b0;
    at(c + 15);
    chk("unmute_busy", int'(busy), 0);
    drain(40);

    c = cyc;
    push(E_NOTE, 3, c + 4);
    push(E_OFF, 0, c + 7);
    pulse(3'b001);
    at(c + 6);
    #1 resetn = 1'b0;
    #1;
    chk("async_en", int'(tone_en), 0);
    chk("async_outs",
        int'({rom_addr, note_idx, busy,
              active_id, done, done_id}), 0);
    #1 resetn = 1'b1;
    @(negedge clk);
    drain(40);

    run_flap();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
- Schedules the single shared tone generator (frequency-table index in, square wave out) among three game sound-effect requesters: flap, score and hit.
- Latches request pulses, arbitrates by fixed priority, and fetches the granted effect's note sequence from an external synchronous note ROM.
- Drives the note index and tone enable to the tone generator, one note per fixed-length slot.

Parameters:
- NOTE_TICKS, 12500000: clk cycles per note PLAY phase (1/8 s at 100 MHz); must be ≥ 2.
- SEQ_LEN, 8: ROM slots per effect; power of 2.
- NOTE_W, 5: note code width.
- ADDR_W, 5: ROM address width; must be ≥ log2(3*SEQ_LEN).

Ports:
- clk  in  1  system clock, 100 MHz
- resetn  in  1  asynchronous active-low reset
- req  in  3  one-cycle request pulses; [0]=flap, [1]=score, [2]=hit
- mute  in  1  level; high aborts playback and blocks grants
- rom_addr  out  ADDR_W  note ROM address
- rom_data  in  NOTE_W  note ROM data, valid the cycle after rom_addr changes
- note_idx  out  NOTE_W  frequency-table index for the tone generator
- tone_en  out  1  tone generator enable
- busy  out  1  high when the state is not IDLE
- active_id  out  2  effect currently playing; 0 when idle
- done  out  1  one-cycle pulse when an effect finishes normally
- done_id  out  2  effect id qualifying done

Behaviour:
- Reset values: all outputs 0; pending=000; state IDLE.
- Note codes:
  - 0–16: valid tone index.
  - 5'h1E: REST. Slot is timed, tone_en=0, note_idx holds its previous value.
  - 5'h1F: END. Terminates the sequence immediately.
  - Codes 17–29: treated as REST.
- ROM layout: effect i occupies addresses i*SEQ_LEN .. i*SEQ_LEN+SEQ_LEN-1.
- Pending:
  - pending[i] is set on a req[i] sample and cleared on the edge where i is granted.
  - A set and a clear of the same bit in one cycle: set wins.
  - When mute=1, req is ignored and pending is held at 0.
- Priority: hit > score > flap.
- Preemption: in FETCH, LOAD or PLAY, a pending id higher than active_id aborts the current effect on the next edge and is granted as from IDLE. An aborted effect produces no done pulse. Equal or lower pending ids wait.
- FSM:
  - IDLE: if pending≠0 and mute=0, grant the highest pending id g. Set active_id=g, slot=0, rom_addr=g*SEQ_LEN, go to FETCH.
  - FETCH: one wait cycle for ROM latency, then go to LOAD.
  - LOAD: sample rom_data.
    - END → FINISH.
    - Otherwise: tone slot sets note_idx=data and tone_en=1; REST slot sets tone_en=0. Clear tick counter, go to PLAY.
  - PLAY: count ticks 0..NOTE_TICKS-1.
    - At terminal count with slot==SEQ_LEN-1 → FINISH.
    - At terminal count otherwise: slot+1, rom_addr+1, go to FETCH.
  - FINISH (one cycle): tone_en=0, done=1, done_id=active_id, active_id=0, then IDLE. Pending requests are evaluated on the following IDLE cycle.
- Outputs during FETCH/LOAD: note_idx and tone_en hold their values, so there are no glitches between notes.
- Note period: NOTE_TICKS+2 cycles.
- Latency: req sampled on edge k gives grant on k+1, rom_addr valid after k+1, and tone_en/note_idx after k+3.
- mute=1 in any non-IDLE state: on the next edge tone_en=0, active_id=0, state IDLE, no done pulse.
- Re-request of the active id while it plays sets pending. The effect replays once after it finishes normally.
- Asynchronous reset mid-playback: all registers return to reset values immediately; tone_en drops without waiting for clk.

Test Plan:
(All scenarios use NOTE_TICKS=4, SEQ_LEN=8.)
- Single flap with ROM[0..2]=3,5,1F: req=001 at edge 0 → rom_addr=0 after edge 1; tone_en=1 and note_idx=3 after edge 3; note_idx=5 six cycles later; then done=1 with done_id=0 for one cycle; busy falls the next cycle.
- Full-length sequence with no END and ROM[8..15]=1..8: exactly 8 notes of 6 cycles each; done_id=1; rom_addr never exceeds 15.
- REST slot with ROM[16..18]=2,1E,4: tone_en low for one slot while note_idx holds 2; then note_idx=4.
- Preemption: flap playing, req=100 mid-PLAY → next edge active_id=2, rom_addr=16; no done for flap. Simultaneous req=011 from idle → score plays first, then flap; two done pulses with ids 1 then 0.
- mute asserted mid-note → tone_en=0 and busy=0 after one edge. req pulses while muted leave pending at 000 after unmute.
- resetn pulsed low mid-PLAY between clk edges → all outputs 0 immediately. After release, a new req is handled normally.
